rs_enc_stream: RTL

Parametrised systematic Reed-Solomon encoder over GF(2^8) with valid/ready streaming and frame delimiting. Message symbols pass through unchanged. After the frame's last symbol, the block appends NPAR parity symbols computed by an LFSR remainder against the generator polynomial g(x). The block sits in the FEC transmit path between the framer and the line interface, and generalises the fixed-parity rsenc to configurable parity count, first consecutive root and flow control.

---
 rtl/rs_enc_stream.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rs_enc_stream.sv
`default_nettype none
// ============================================================================
// Module  : rs_enc_stream
// Systematic Reed-Solomon encoder over GF(2^8), valid/ready streaming,
// NPAR parity symbols appended after each frame, highest degree first.
// Revision: 1.0 - initial release
// ============================================================================
module rs_enc_stream #(
  parameter int         NPAR = 4,
  parameter int         FCR  = 0,
  parameter logic [8:0] PRIM = 9'h11D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_parity,
  output logic       out_last
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[7] ? ((sh << 1) ^ PRIM[7:0]) : (sh << 1);
    end
    return acc;
  endfunction

  // Multiplies out prod (x + alpha^(FCR+i)); the monic x^NPAR term is dropped.
  function automatic logic [NPAR*8-1:0] gen_poly();
    logic [7:0]        p [0:NPAR];
    logic [7:0]        root;
    logic [NPAR*8-1:0] res;
    for (int j = 0; j <= NPAR; j++) p[j] = 8'h00;
    p[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < (FCR % 255); i++) root = gf_mul(root, 8'h02);
    for (int i = 0; i < NPAR; i++) begin
      for (int j = NPAR; j >= 1; j--) p[j] = p[j-1] ^ gf_mul(p[j], root);
      p[0] = gf_mul(p[0], root);
      root = gf_mul(root, 8'h02);
    end
    for (int j = 0; j < NPAR; j++) res[j*8 +: 8] = p[j];
    return res;
  endfunction

  localparam logic [NPAR*8-1:0] GEN       = gen_poly();
  localparam logic [5:0]        PCNT_LAST = 6'(NPAR - 1);

  typedef enum logic [0:0] {
    S_DATA   = 1'b0,
    S_PARITY = 1'b1
  } state_t;

  state_t                state_q;
  logic [NPAR-1:0][7:0]  rem_q;
  logic [NPAR-1:0][7:0]  rem_d;
  logic [5:0]            pcnt_q;
  logic                  slot_free;
  logic                  accept;
  logic                  emit;
  logic [7:0]            fb;

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = !rst && (state_q == S_DATA) && slot_free;
  assign accept    = in_valid && in_ready;
  assign emit      = (state_q == S_PARITY) && slot_free;

  always_comb begin
    rem_d = rem_q;
    fb    = in_data ^ rem_q[NPAR-1];
    if (accept) begin
      for (int k = NPAR - 1; k >= 1; k--) rem_d[k] = rem_q[k-1] ^ gf_mul(fb, GEN[k*8 +: 8]);
      rem_d[0] = gf_mul(fb, GEN[7:0]);
    end else if (emit) begin
      // Shifting out the parity leaves the remainder zero for the next frame.
      for (int k = NPAR - 1; k >= 1; k--) rem_d[k] = rem_q[k-1];
      rem_d[0] = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_DATA;
      rem_q      <= '0;
      pcnt_q     <= '0;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_parity <= 1'b0;
      out_last   <= 1'b0;
    end else begin
      rem_q <= rem_d;
      if (slot_free) out_valid <= 1'b0;
      case (state_q)
        S_DATA: begin
          if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= in_data;
            out_parity <= 1'b0;
            out_last   <= 1'b0;
            if (in_last) begin
              state_q <= S_PARITY;
              pcnt_q  <= '0;
            end
          end
        end
        S_PARITY: begin
          if (emit) begin
            out_valid  <= 1'b1;
            out_data   <= rem_q[NPAR-1];
            out_parity <= 1'b1;
            out_last   <= (pcnt_q == PCNT_LAST);
            pcnt_q     <= pcnt_q + 6'd1;
            if (pcnt_q == PCNT_LAST) state_q <= S_DATA;
          end
        end
        default: state_q <= S_DATA;
      endcase
    end
  end

endmodule
`default_nettype wire
